// File: rtl/stage_sequence_monitor.sv
// Passive checker for the multicycle stage sequencer: follows the one-hot IF/ID/EX/MEM/RW
// strobes, validates each transition against the decoded instruction and reports retirements.
module stage_sequence_monitor #(
    parameter int CNT_W        = 16,
    parameter bit CHECK_DECODE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             IF,
    input  logic             ID,
    input  logic             EX,
    input  logic             MEM,
    input  logic             RW,
    input  logic [1:0]       insType,
    input  logic [4:0]       func,
    output logic             synced,
    output logic             retire,
    output logic [2:0]       last_cycles,
    output logic [2:0]       last_path,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err,
    output logic [2:0]       err_code
);

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EX  = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_RW  = 3'd4;

    localparam logic [0:0] MON_UNSYNC = 1'b0;
    localparam logic [0:0] MON_SYNC   = 1'b1;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ONEHOT = 3'd1;
    localparam logic [2:0] ERR_GRAPH  = 3'd2;
    localparam logic [2:0] ERR_DECODE = 3'd3;

    localparam logic [2:0] PATH_J    = 3'd0;
    localparam logic [2:0] PATH_EXT  = 3'd1;
    localparam logic [2:0] PATH_MEMT = 3'd2;
    localparam logic [2:0] PATH_ALU  = 3'd3;
    localparam logic [2:0] PATH_LD   = 3'd4;

    logic [0:0] mon_state;
    logic [2:0] prev_stage;
    logic [1:0] prev_type;
    logic [4:0] prev_func;
    logic [2:0] stage_cnt;

    logic [4:0] strobes;
    logic       one_hot;
    logic [2:0] cur_stage;
    logic [2:0] exp_stage;
    logic       in_graph;
    logic [2:0] fault_code;
    logic [2:0] path_class;

    assign strobes = {RW, MEM, EX, ID, IF};
    assign one_hot = (strobes != 5'd0) && ((strobes & (strobes - 5'd1)) == 5'd0);
    assign synced  = (mon_state == MON_SYNC);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_stage = ST_IF;
        case (strobes)
            5'b00001: cur_stage = ST_IF;
            5'b00010: cur_stage = ST_ID;
            5'b00100: cur_stage = ST_EX;
            5'b01000: cur_stage = ST_MEM;
            5'b10000: cur_stage = ST_RW;
            default:  cur_stage = ST_IF;
        endcase
    end

    // Successor the sequencer should take, from the type/func it decoded on the previous edge.
    always_comb begin
        exp_stage = ST_IF;
        case (prev_stage)
            ST_IF: exp_stage = ST_ID;
            ST_ID: begin
                if (prev_type == 2'b10 && prev_func == 5'd0) exp_stage = ST_IF;
                else                                         exp_stage = ST_EX;
            end
            ST_EX: begin
                if (prev_type == 2'b10
                    || (prev_type == 2'b01 && prev_func == 5'b00100)
                    || (prev_type == 2'b00 && prev_func == 5'b00011))
                    exp_stage = ST_IF;
                else if (prev_type == 2'b01 && (prev_func == 5'b00010 || prev_func == 5'b00011))
                    exp_stage = ST_MEM;
                else
                    exp_stage = ST_RW;
            end
            ST_MEM: begin
                if (prev_type == 2'b01 && prev_func == 5'b00010) exp_stage = ST_RW;
                else                                             exp_stage = ST_IF;
            end
            default: exp_stage = ST_IF;
        endcase
    end

    always_comb begin
        in_graph = 1'b0;
        case (prev_stage)
            ST_IF:   in_graph = (cur_stage == ST_ID);
            ST_ID:   in_graph = (cur_stage == ST_IF) || (cur_stage == ST_EX);
            ST_EX:   in_graph = (cur_stage == ST_IF) || (cur_stage == ST_MEM) || (cur_stage == ST_RW);
            ST_MEM:  in_graph = (cur_stage == ST_IF) || (cur_stage == ST_RW);
            ST_RW:   in_graph = (cur_stage == ST_IF);
            default: in_graph = 1'b0;
        endcase
    end

    always_comb begin
        fault_code = ERR_NONE;
        if (!one_hot)
            fault_code = ERR_ONEHOT;
        else if (!in_graph)
            fault_code = ERR_GRAPH;
        else if (CHECK_DECODE && (cur_stage != exp_stage))
            fault_code = ERR_DECODE;
    end

    // The last stage before IF plus the stage count identify the path uniquely.
    always_comb begin
        path_class = PATH_J;
        case (prev_stage)
            ST_ID:   path_class = PATH_J;
            ST_EX:   path_class = PATH_EXT;
            ST_MEM:  path_class = PATH_MEMT;
            ST_RW:   path_class = (stage_cnt == 3'd5) ? PATH_LD : PATH_ALU;
            default: path_class = PATH_J;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mon_state     <= MON_UNSYNC;
            prev_stage    <= ST_IF;
            prev_type     <= 2'd0;
            prev_func     <= 5'd0;
            stage_cnt     <= 3'd0;
            retire        <= 1'b0;
            last_cycles   <= 3'd0;
            last_path     <= 3'd0;
            retired_count <= '0;
            cycle_count   <= '0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            retire <= 1'b0;
            if (one_hot) begin
                prev_stage <= cur_stage;
                prev_type  <= insType;
                prev_func  <= func;
            end

            if (mon_state == MON_UNSYNC) begin
                if (one_hot && cur_stage == ST_IF) begin
                    mon_state   <= MON_SYNC;
                    stage_cnt   <= 3'd1;
                    cycle_count <= cycle_count + CNT_W'(1);
                end
            end else begin
                cycle_count <= cycle_count + CNT_W'(1);
                if (fault_code != ERR_NONE) begin
                    // The in-flight instruction is dropped; a fresh IF is needed to resync.
                    mon_state <= MON_UNSYNC;
                    stage_cnt <= 3'd0;
                    err       <= 1'b1;
                    if (err_code == ERR_NONE)
                        err_code <= fault_code;
                end else if (cur_stage == ST_IF) begin
                    retire        <= 1'b1;
                    last_cycles   <= stage_cnt;
                    last_path     <= path_class;
                    retired_count <= retired_count + CNT_W'(1);
                    stage_cnt     <= 3'd1;
                end else begin
                    stage_cnt <= stage_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_sequence_monitor.sv
// Randomised bench for stage_sequence_monitor: three configurations driven in parallel and
// scoreboarded against a sequence-level reference model.
module tb_stage_sequence_monitor;

    localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_RW = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] stb;
    logic [1:0] ins_type;
    logic [4:0] func;

    logic        synced_o [3];
    logic        retire_o [3];
    logic [2:0]  lc_o     [3];
    logic [2:0]  lp_o     [3];
    logic [15:0] rc_o     [3];
    logic [15:0] cc_o     [3];
    logic        err_o    [3];
    logic [2:0]  ec_o     [3];
    logic [3:0]  rc_w4, cc_w4;

    assign rc_o[2] = {12'd0, rc_w4};
    assign cc_o[2] = {12'd0, cc_w4};

    always #5 clock = ~clock;

    stage_sequence_monitor #(.CNT_W(16), .CHECK_DECODE(1'b1)) dut (
        .clock(clock), .reset(reset),
        .IF(stb[0]), .ID(stb[1]), .EX(stb[2]), .MEM(stb[3]), .RW(stb[4]),
        .insType(ins_type), .func(func),
        .synced(synced_o[0]), .retire(retire_o[0]), .last_cycles(lc_o[0]), .last_path(lp_o[0]),
        .retired_count(rc_o[0]), .cycle_count(cc_o[0]), .err(err_o[0]), .err_code(ec_o[0])
    );

    stage_sequence_monitor #(.CNT_W(16), .CHECK_DECODE(1'b0)) dut_nodec (
        .clock(clock), .reset(reset),
        .IF(stb[0]), .ID(stb[1]), .EX(stb[2]), .MEM(stb[3]), .RW(stb[4]),
        .insType(ins_type), .func(func),
        .synced(synced_o[1]), .retire(retire_o[1]), .last_cycles(lc_o[1]), .last_path(lp_o[1]),
        .retired_count(rc_o[1]), .cycle_count(cc_o[1]), .err(err_o[1]), .err_code(ec_o[1])
    );

    stage_sequence_monitor #(.CNT_W(4), .CHECK_DECODE(1'b1)) dut_w4 (
        .clock(clock), .reset(reset),
        .IF(stb[0]), .ID(stb[1]), .EX(stb[2]), .MEM(stb[3]), .RW(stb[4]),
        .insType(ins_type), .func(func),
        .synced(synced_o[2]), .retire(retire_o[2]), .last_cycles(lc_o[2]), .last_path(lp_o[2]),
        .retired_count(rc_w4), .cycle_count(cc_w4), .err(err_o[2]), .err_code(ec_o[2])
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: actual %0d expected %0d", name, actual, expected);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cycles; int path; int rc; } exp_t;
    exp_t q0[$], q1[$], q2[$];

    bit cfg_dc   [3] = '{1'b1, 1'b0, 1'b1};
    int cfg_mask [3] = '{32'hFFFF, 32'hFFFF, 32'hF};

    int m_sync[3], m_cc[3], m_rc[3], m_err[3], m_code[3], m_ret[3];
    int m_prev[3], m_pt[3], m_pf[3], m_len[3];
    int m_seq[3][8];

    // Canonical stage lists of the five instruction classes, indexed by path code.
    int canon[5][5] = '{'{0, 1, -1, -1, -1}, '{0, 1, 2, -1, -1}, '{0, 1, 2, 3, -1},
                        '{0, 1, 2, 4, -1}, '{0, 1, 2, 3, 4}};

    function automatic int exp_next(input int p, input int t, input int f);
        case (p)
            S_IF:  return S_ID;
            S_ID:  return (t == 2 && f == 0) ? S_IF : S_EX;
            S_EX:  begin
                if (t == 2 || (t == 1 && f == 4) || (t == 0 && f == 3)) return S_IF;
                if (t == 1 && (f == 2 || f == 3)) return S_MEM;
                return S_RW;
            end
            S_MEM: return (t == 1 && f == 2) ? S_RW : S_IF;
            default: return S_IF;
        endcase
    endfunction

    function automatic bit legal_edge(input int p, input int c);
        case (p)
            S_IF:  return c == S_ID;
            S_ID:  return c == S_IF || c == S_EX;
            S_EX:  return c == S_IF || c == S_MEM || c == S_RW;
            S_MEM: return c == S_IF || c == S_RW;
            S_RW:  return c == S_IF;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int classify(input int k);
        for (int p = 0; p < 5; p++) begin
            bit match = 1'b1;
            for (int i = 0; i < 5; i++) begin
                int v = (i < m_len[k]) ? m_seq[k][i] : -1;
                if (v != canon[p][i]) match = 1'b0;
            end
            if (match) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sync[k] = 0; m_cc[k] = 0; m_rc[k] = 0; m_err[k] = 0; m_code[k] = 0;
            m_ret[k] = 0; m_prev[k] = 0; m_pt[k] = 0; m_pf[k] = 0; m_len[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input bit [4:0] s, input int t, input int f);
        int  cur  = -1;
        int  code = 0;
        bit  oh   = ($countones(s) == 1);
        exp_t e;
        m_ret[k] = 0;
        for (int i = 0; i < 5; i++) if (oh && s[i]) cur = i;
        if (!m_sync[k]) begin
            if (cur == S_IF) begin
                m_sync[k] = 1; m_len[k] = 1; m_seq[k][0] = S_IF;
                m_cc[k] = (m_cc[k] + 1) & cfg_mask[k];
            end
        end else begin
            m_cc[k] = (m_cc[k] + 1) & cfg_mask[k];
            if (!oh) code = 1;
            else if (!legal_edge(m_prev[k], cur)) code = 2;
            else if (cfg_dc[k] && cur != exp_next(m_prev[k], m_pt[k], m_pf[k])) code = 3;
            if (code != 0) begin
                m_err[k] = 1;
                if (m_code[k] == 0) m_code[k] = code;
                m_sync[k] = 0;
            end else if (cur == S_IF) begin
                m_rc[k]  = (m_rc[k] + 1) & cfg_mask[k];
                m_ret[k] = 1;
                e.cycles = m_len[k]; e.path = classify(k); e.rc = m_rc[k];
                case (k)
                    0: q0.push_back(e);
                    1: q1.push_back(e);
                    default: q2.push_back(e);
                endcase
                m_len[k] = 1; m_seq[k][0] = S_IF;
            end else begin
                m_seq[k][m_len[k]] = cur;
                m_len[k]++;
            end
        end
        if (oh) begin m_prev[k] = cur; m_pt[k] = t; m_pf[k] = f; end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic mon(input int k);
        exp_t e;
        int   sz;
        if (retire_o[k]) begin
            case (k)
                0: sz = q0.size();
                1: sz = q1.size();
                default: sz = q2.size();
            endcase
            check($sformatf("sb%0d_retire_expected", k), (sz > 0) ? 1 : 0, 1);
            if (sz > 0) begin
                case (k)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                check($sformatf("sb%0d_last_cycles", k), int'(lc_o[k]), e.cycles);
                check($sformatf("sb%0d_last_path", k), int'(lp_o[k]), e.path);
                check($sformatf("sb%0d_retired_count", k), int'(rc_o[k]), e.rc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) for (int k = 0; k < 3; k++) mon(k);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit [4:0] s, input int t, input int f);
        stb = s; ins_type = 2'(t); func = 5'(f);
        for (int k = 0; k < 3; k++) model_edge(k, s, t, f);
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string name);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_synced%0d", name, k), int'(synced_o[k]), m_sync[k]);
            check($sformatf("%s_retire%0d", name, k), int'(retire_o[k]), m_ret[k]);
            check($sformatf("%s_rc%0d", name, k), int'(rc_o[k]), m_rc[k]);
            check($sformatf("%s_cc%0d", name, k), int'(cc_o[k]), m_cc[k]);
            check($sformatf("%s_err%0d", name, k), int'(err_o[k]), m_err[k]);
            check($sformatf("%s_code%0d", name, k), int'(ec_o[k]), m_code[k]);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_rst_synced%0d", name, k), int'(synced_o[k]), 0);
            check($sformatf("%s_rst_retire%0d", name, k), int'(retire_o[k]), 0);
            check($sformatf("%s_rst_lc%0d", name, k), int'(lc_o[k]), 0);
            check($sformatf("%s_rst_lp%0d", name, k), int'(lp_o[k]), 0);
            check($sformatf("%s_rst_rc%0d", name, k), int'(rc_o[k]), 0);
            check($sformatf("%s_rst_cc%0d", name, k), int'(cc_o[k]), 0);
            check($sformatf("%s_rst_err%0d", name, k), int'(err_o[k]), 0);
            check($sformatf("%s_rst_code%0d", name, k), int'(ec_o[k]), 0);
        end
        check($sformatf("%s_sb_drained", name), q0.size() + q1.size() + q2.size(), 0);
        q0.delete(); q1.delete(); q2.delete();
        model_reset();
        stb = 5'd0;
        reset = 1'b0;
        step(5'd0, 0, 0);
    endtask

    // Walks the decoded path of one instruction up to (not including) the next IF.
    task automatic issue_ins(input int t, input int f);
        int cur = S_IF;
        step(5'(1 << cur), t, f);
        for (int i = 0; i < 5; i++) begin
            int nxt = exp_next(cur, t, f);
            if (nxt == S_IF) break;
            cur = nxt;
            step(5'(1 << cur), t, f);
        end
    endtask

    task automatic issue_rand_ins();
        int t = $urandom_range(0, 3);
        int f = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 31);
        int cur = S_IF;
        for (int i = 0; i < 6; i++) begin
            bit [4:0] s = 5'(1 << cur);
            if ($urandom_range(0, 24) == 0) s = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 39) == 0) s = 5'd0;
            step(s, t, f);
            cur = exp_next(cur, t, f);
            if (cur == S_IF) break;
        end
    endtask

    initial begin
        reset = 1'b1; stb = 5'd0; ins_type = 2'd0; func = 5'd0;
        model_reset();
        @(posedge clock);
        #1;

        // Test 1: jump retires after two stages
        do_reset("t1");
        issue_ins(2, 0);
        step(5'b00001, 0, 0);
        check("t1_retire", int'(retire_o[0]), 1);
        check("t1_last_cycles", int'(lc_o[0]), 2);
        check("t1_last_path", int'(lp_o[0]), 0);
        check("t1_retired_count", int'(rc_o[0]), 1);
        check_state("t1");

        // Test 2: load walks all five stages
        do_reset("t2");
        issue_ins(1, 2);
        step(5'b00001, 0, 0);
        check("t2_last_cycles", int'(lc_o[0]), 5);
        check("t2_last_path", int'(lp_o[0]), 4);
        check("t2_cycle_count", int'(cc_o[0]), 6);
        check_state("t2");

        // Test 3: back-to-back ALU then store
        do_reset("t3");
        for (int i = 0; i < 3; i++) issue_ins(0, 1);
        issue_ins(1, 3);
        step(5'b00001, 0, 0);
        check("t3_retired_count", int'(rc_o[0]), 4);
        check("t3_last_path", int'(lp_o[0]), 2);
        check("t3_last_cycles", int'(lc_o[0]), 4);
        check_state("t3");

        // Test 4: two strobes at once, then resync
        do_reset("t4");
        step(5'b00001, 0, 1);
        step(5'b00010, 0, 1);
        step(5'b00011, 0, 1);
        check("t4_err", int'(err_o[0]), 1);
        check("t4_err_code", int'(ec_o[0]), 1);
        check("t4_synced", int'(synced_o[0]), 0);
        check("t4_no_retire", int'(retire_o[0]), 0);
        step(5'd0, 0, 0);
        issue_ins(2, 0);
        check("t4_resynced", int'(synced_o[0]), 1);
        check("t4_code_sticky", int'(ec_o[0]), 1);
        check_state("t4");

        // Test 5: ALU taking EX->MEM
        do_reset("t5");
        step(5'b00001, 0, 1);
        step(5'b00010, 0, 1);
        step(5'b00100, 0, 1);
        step(5'b01000, 0, 1);
        check("t5_err_code", int'(ec_o[0]), 3);
        check("t5_nodec_err", int'(err_o[1]), 0);
        step(5'b00001, 0, 1);
        check("t5_nodec_retire", int'(retire_o[1]), 1);
        check("t5_nodec_path", int'(lp_o[1]), 2);
        check_state("t5");

        // Test 6: IF->EX skip, reset mid-load, narrow counter wrap
        do_reset("t6a");
        step(5'b00001, 0, 1);
        step(5'b00100, 0, 1);
        check("t6_err_code", int'(ec_o[0]), 2);
        check_state("t6a");
        do_reset("t6b");
        step(5'b00001, 1, 2);
        step(5'b00010, 1, 2);
        step(5'b00100, 1, 2);
        step(5'b01000, 1, 2);
        check("t6_mid_synced", int'(synced_o[0]), 1);
        do_reset("t6c");
        for (int i = 0; i < 16; i++) issue_ins(2, 0);
        step(5'b00001, 0, 0);
        check("t6_wrap_w4", int'(rc_w4), 0);
        check("t6_wide_16", int'(rc_o[0]), 16);
        check_state("t6c");

        // Randomised instruction stream with occasional corrupted strobes
        do_reset("rnd");
        for (int n = 0; n < 300; n++) begin
            issue_rand_ins();
            if (n % 50 == 49) check_state($sformatf("rnd%0d", n));
        end
        step(5'b00001, 0, 0);
        check_state("rnd_end");
        do_reset("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
